// File: rtl/permute_pkg.sv
// permute_pkg: shared FSM state type and parameter defaults for the permute controller
package permute_pkg;
  localparam int N_DEF = 25;
  localparam int SLICES_DEF = 64;
  localparam int AW_DEF = 6;
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, PERMUTE, WRITE, FINISH} state_t;
endpackage

// File: rtl/permute_slice_counter.sv
// permute_slice_counter: loadable up/down slice counter that saturates instead of wrapping
// Ports: clk, rst (sync, active-high, reloads LOAD_VAL), load (reload LOAD_VAL),
//        en (count step), down (1 = decrement, 0 = increment), count, co (count == 0)
module permute_slice_counter #(
  parameter int AW = 6,
  parameter int LOAD_VAL = 63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic          down,
  output logic [AW-1:0] count,
  output logic          co
);
  assign co = count == '0;
  always_ff @(posedge clk)
    if (rst || load) count <= AW'(LOAD_VAL);
    else if (en) count <= down ? (co ? count : count - 1'b1) : (&count ? count : count + 1'b1);
endmodule

// File: rtl/permute_ctrl.sv
// permute_ctrl: sequences read/capture/permute/write over every slice of one state
// Ports: clk, rst (sync, active-high), start (one-cycle request), busy, done (one-cycle pulse),
//        rd_en/rd_addr (source read), reg_en/sel (line register enable, 0=read line 1=permuted),
//        wr_en/wr_addr/wr_ready (sink write handshake), cycles (status cycle count).
// Optional feature: define PERMUTE_CTRL_CYCLE_CNT_EN to build the saturating cycle counter;
// otherwise cycles is tied to 0.
module permute_ctrl
  import permute_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int SLICES = SLICES_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          reg_en,
  output logic          sel,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  input  logic          wr_ready,
  output logic [15:0]   cycles
);
  if (N < 1 || (1 << AW) < SLICES) begin : g_bad_cfg
    $error("permute_ctrl: N must be positive and 2**AW must cover SLICES");
  end
  state_t state;
  logic [AW-1:0] count;
  logic co;
  logic accept;
  logic wr_ok;
  assign accept = state == IDLE && start;
  assign wr_ok = state == WRITE && wr_ready;
  permute_slice_counter #(.AW(AW), .LOAD_VAL(SLICES - 1)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept || state == FINISH),
    .en   (wr_ok && !co),
    .down (1'b1),
    .count(count),
    .co   (co)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else
      case (state)
        IDLE:    state <= start ? READ : IDLE;
        READ:    state <= CAPTURE;
        CAPTURE: state <= PERMUTE;
        PERMUTE: state <= WRITE;
        WRITE:   state <= wr_ready ? (co ? FINISH : READ) : WRITE;
        default: state <= IDLE;
      endcase
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign rd_en = state == READ;
  assign reg_en = state == CAPTURE || state == PERMUTE;
  assign sel = state == PERMUTE;
  assign wr_en = state == WRITE;
  assign rd_addr = count;
  assign wr_addr = count;
`ifdef PERMUTE_CTRL_CYCLE_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk)
    if (rst || accept) cnt <= '0;
    else if (busy && cnt != 16'hFFFF) cnt <= cnt + 1'b1;
  assign cycles = cnt;
`else
  assign cycles = '0;
`endif
endmodule

// File: tb/tb_permute_ctrl.sv
// tb_permute_ctrl: directed scoreboard bench for permute_ctrl
module tb_permute_ctrl;
  localparam int SL = 64;
`ifdef PERMUTE_CTRL_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 0, rst = 1, start = 0, wr_ready = 1;
  logic busy, done, rd_en, reg_en, sel, wr_en;
  logic [5:0] rd_addr, wr_addr;
  logic [15:0] cycles;
  int tests = 0, fails = 0, cyc = 0, sc = 0, writes = 0, dones = 0, n;
  int rd_q[$], wr_q[$];
  logic prev_reg_en = 0, prev_sel = 0;

  permute_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .reg_en(reg_en), .sel(sel),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_ready(wr_ready), .cycles(cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot", int'(rd_en) + int'(reg_en) + int'(wr_en) <= 1, 1);
      chk("sel_only_permute", sel, reg_en && prev_reg_en && !prev_sel);
      if (rd_en) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", rd_addr, rd_q.pop_front());
      end
      if (wr_en && wr_ready) begin
        writes++;
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr_addr", wr_addr, wr_q.pop_front());
      end
      if (done) dones++;
    end
    prev_reg_en = reg_en;
    prev_sel = sel;
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1;
    sc = cyc;
    writes = 0;
    dones = 0;
    for (int a = SL - 1; a >= 0; a--) begin
      rd_q.push_back(a);
      wr_q.push_back(a);
    end
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag, input int lat);
    int k = 0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_latency"}, cyc - sc, lat);
      chk({tag, "_busy_at_done"}, busy, 1);
      @(negedge clk);
      chk({tag, "_busy_after"}, busy, 0);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_writes"}, writes, SL);
      chk({tag, "_dones"}, dones, 1);
      chk({tag, "_q_empty"}, rd_q.size() + wr_q.size(), 0);
      chk({tag, "_cycles"}, cycles, CNT_EN ? lat : 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_strobes", {rd_en, reg_en, wr_en, sel}, 0);
    chk("rst_rd_addr", rd_addr, 63);
    chk("rst_wr_addr", wr_addr, 63);
    chk("rst_cycles", cycles, 0);
    rst = 0;
    // full unstalled run
    pulse_start();
    wait_done("run1", 4 * SL + 1);
    // stall 5 cycles on slice 40
    pulse_start();
    n = 0;
    while (!(rd_en && rd_addr == 6'd40) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach40", int'(rd_en && rd_addr == 6'd40), 1);
    wr_ready = 0;
    n = 0;
    while (!wr_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("stall_wr_en", wr_en, 1);
      chk("stall_wr_addr", wr_addr, 40);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    wr_ready = 1;
    wait_done("stall", 4 * SL + 6);
    // start re-asserted while busy
    pulse_start();
    while (cyc < sc + 10) @(posedge clk);
    #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done("restart_ignored", 4 * SL + 1);
    // reset mid-operation
    pulse_start();
    while (cyc < sc + 100) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    rd_q.delete();
    wr_q.delete();
    chk("abort_busy", busy, 0);
    chk("abort_count", rd_addr, 63);
    chk("abort_done", done, 0);
    chk("abort_cycles", cycles, 0);
    dones = 0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", dones, 0);
    chk("abort_idle", busy, 0);
    pulse_start();
    wait_done("after_abort", 4 * SL + 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
